// File: rtl/sb_sched_pkg.sv
// -----------------------------------------------------------------------------
// sb_sched_pkg
// Shared types and constants for the sideband transaction scheduler.
//   sched_state_e : scheduler FSM states (DISC, IDLE, WAIT_SENT)
//   SEL_*         : trans_sel codes understood by the SB transaction generator
// -----------------------------------------------------------------------------
package sb_sched_pkg;

   typedef enum logic [1:0] {
      DISC      = 2'd0,
      IDLE      = 2'd1,
      WAIT_SENT = 2'd2
   } sched_state_e;

   localparam logic [2:0] SEL_NONE   = 3'd0;
   localparam logic [2:0] SEL_AT_CMD = 3'd2;
   localparam logic [2:0] SEL_AT_RSP = 3'd3;
   localparam logic [2:0] SEL_LT     = 3'd4;

   // One-hot grant bit positions returned by the arbiter.
   localparam int GNT_LT  = 2;
   localparam int GNT_RSP = 1;
   localparam int GNT_CMD = 0;

endpackage

// File: rtl/sb_sched_arb.sv
// -----------------------------------------------------------------------------
// sb_sched_arb
// Combinational fixed-priority picker: LT > AT response > AT command.
// Ports:
//   pend_lt_i  : LT request pending
//   pend_rsp_i : AT response pending
//   pend_cmd_i : AT command pending and eligible (no command outstanding)
//   sel_o      : trans_sel code of the winner, SEL_NONE if nothing pending
//   gnt_o      : one-hot grant {lt, rsp, cmd}
// -----------------------------------------------------------------------------
module sb_sched_arb
   import sb_sched_pkg::*;
(
   input  logic       pend_lt_i,
   input  logic       pend_rsp_i,
   input  logic       pend_cmd_i,
   output logic [2:0] sel_o,
   output logic [2:0] gnt_o
);

   // Fixed-priority selection of the next transaction.
   always_comb begin
      sel_o = SEL_NONE;
      gnt_o = 3'b000;
      if (pend_lt_i) begin
         sel_o          = SEL_LT;
         gnt_o[GNT_LT]  = 1'b1;
      end else if (pend_rsp_i) begin
         sel_o          = SEL_AT_RSP;
         gnt_o[GNT_RSP] = 1'b1;
      end else if (pend_cmd_i) begin
         sel_o          = SEL_AT_CMD;
         gnt_o[GNT_CMD] = 1'b1;
      end else begin
         sel_o = SEL_NONE;
         gnt_o = 3'b000;
      end
   end

endmodule

// File: rtl/sb_trans_scheduler.sv
// -----------------------------------------------------------------------------
// sb_trans_scheduler
// Latches LT / AT-response / AT-command requests, issues a one-cycle trans_sel
// to the SB transaction generator, waits for trans_sent and supervises the
// response window of outstanding AT commands.
// Optional build macro: SB_SCHED_RETRY_EN (re-issue AT command on response
// timeout up to MAX_RETRY times before reporting at_timeout).
// Ports:
//   sb_clk, rst (async, active-low)
//   lt_req / at_cmd_req / at_rsp_req : request pulses
//   at_rsp_rcvd    : far-end response to an AT command
//   trans_sent     : generator done pulse
//   disconnected_s : generator disconnected, forces DISC
//   trans_sel      : one-cycle code to the generator
//   lt_done / at_cmd_done / at_rsp_done / at_timeout : completion pulses
//   gen_err        : sticky generator-hang flag
//   busy           : high whenever the FSM is not IDLE
// All outputs are registered.
// -----------------------------------------------------------------------------
module sb_trans_scheduler
   import sb_sched_pkg::*;
#(
   parameter int RSP_TIMEOUT = 1000,
   parameter int SENT_GUARD  = 255,
   parameter int CNT_W       = 10
`ifdef SB_SCHED_RETRY_EN
   ,
   parameter int MAX_RETRY   = 2
`endif
) (
   input  logic       sb_clk,
   input  logic       rst,
   input  logic       lt_req,
   input  logic       at_cmd_req,
   input  logic       at_rsp_req,
   input  logic       at_rsp_rcvd,
   input  logic       trans_sent,
   input  logic       disconnected_s,
   output logic [2:0] trans_sel,
   output logic       lt_done,
   output logic       at_cmd_done,
   output logic       at_rsp_done,
   output logic       at_timeout,
   output logic       gen_err,
   output logic       busy
);

   // Counters fire on the edge where they would reach their limit.
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(SENT_GUARD - 1);
   localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(RSP_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

`ifdef SB_SCHED_RETRY_EN
   localparam int RETRY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
   logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
`endif

   sched_state_e     state_q, state_d;
   logic             pend_lt_q, pend_lt_d;
   logic             pend_rsp_q, pend_rsp_d;
   logic             pend_cmd_q, pend_cmd_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0] rsp_timer_q, rsp_timer_d;
   logic             cmd_out_q, cmd_out_d;
   logic [2:0]       cur_sel_q, cur_sel_d;
   logic [2:0]       trans_sel_q, trans_sel_d;
   logic             lt_done_q, lt_done_d;
   logic             at_cmd_done_q, at_cmd_done_d;
   logic             at_rsp_done_q, at_rsp_done_d;
   logic             at_timeout_q, at_timeout_d;
   logic             gen_err_q, gen_err_d;
   logic             busy_q, busy_d;

   logic [2:0]       arb_sel;
   logic [2:0]       arb_gnt;

   // Saturating increment for the shared timer width.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         return v;
      end else begin
         return v + CNT_W'(1);
      end
   endfunction

   sb_sched_arb u_arb (
      .pend_lt_i  (pend_lt_q),
      .pend_rsp_i (pend_rsp_q),
      .pend_cmd_i (pend_cmd_q & ~cmd_out_q),
      .sel_o      (arb_sel),
      .gnt_o      (arb_gnt)
   );

   // State and datapath registers.
   always_ff @(posedge sb_clk or negedge rst) begin
      if (!rst) begin
         state_q       <= DISC;
         pend_lt_q     <= 1'b0;
         pend_rsp_q    <= 1'b0;
         pend_cmd_q    <= 1'b0;
         timer_q       <= CNT_ZERO;
         rsp_timer_q   <= CNT_ZERO;
         cmd_out_q     <= 1'b0;
         cur_sel_q     <= SEL_NONE;
         trans_sel_q   <= SEL_NONE;
         lt_done_q     <= 1'b0;
         at_cmd_done_q <= 1'b0;
         at_rsp_done_q <= 1'b0;
         at_timeout_q  <= 1'b0;
         gen_err_q     <= 1'b0;
         busy_q        <= 1'b0;
`ifdef SB_SCHED_RETRY_EN
         retry_cnt_q   <= {RETRY_W{1'b0}};
`endif
      end else begin
         state_q       <= state_d;
         pend_lt_q     <= pend_lt_d;
         pend_rsp_q    <= pend_rsp_d;
         pend_cmd_q    <= pend_cmd_d;
         timer_q       <= timer_d;
         rsp_timer_q   <= rsp_timer_d;
         cmd_out_q     <= cmd_out_d;
         cur_sel_q     <= cur_sel_d;
         trans_sel_q   <= trans_sel_d;
         lt_done_q     <= lt_done_d;
         at_cmd_done_q <= at_cmd_done_d;
         at_rsp_done_q <= at_rsp_done_d;
         at_timeout_q  <= at_timeout_d;
         gen_err_q     <= gen_err_d;
         busy_q        <= busy_d;
`ifdef SB_SCHED_RETRY_EN
         retry_cnt_q   <= retry_cnt_d;
`endif
      end
   end

   // Next-state logic; disconnect overrides every state.
   always_comb begin
      state_d = state_q;
      if (disconnected_s) begin
         state_d = DISC;
      end else begin
         case (state_q)
            DISC:      state_d = IDLE;
            IDLE:      state_d = (arb_sel != SEL_NONE) ? WAIT_SENT : IDLE;
            WAIT_SENT: state_d = (trans_sent || (timer_q == GUARD_LAST)) ? IDLE : WAIT_SENT;
            default:   state_d = DISC;
         endcase
      end
   end

   // Flags, timers and registered output values.
   always_comb begin
      pend_lt_d     = pend_lt_q;
      pend_rsp_d    = pend_rsp_q;
      pend_cmd_d    = pend_cmd_q;
      timer_d       = timer_q;
      rsp_timer_d   = rsp_timer_q;
      cmd_out_d     = cmd_out_q;
      cur_sel_d     = cur_sel_q;
      gen_err_d     = gen_err_q;
      trans_sel_d   = SEL_NONE;
      lt_done_d     = 1'b0;
      at_cmd_done_d = 1'b0;
      at_rsp_done_d = 1'b0;
      at_timeout_d  = 1'b0;
      busy_d        = (state_d != IDLE);
`ifdef SB_SCHED_RETRY_EN
      retry_cnt_d   = retry_cnt_q;
`endif

      if (disconnected_s || (state_q == DISC)) begin
         // Drop everything in flight; requests are not latched while down.
         pend_lt_d   = 1'b0;
         pend_rsp_d  = 1'b0;
         pend_cmd_d  = 1'b0;
         timer_d     = CNT_ZERO;
         rsp_timer_d = CNT_ZERO;
         cmd_out_d   = 1'b0;
         cur_sel_d   = SEL_NONE;
         gen_err_d   = 1'b0;
`ifdef SB_SCHED_RETRY_EN
         retry_cnt_d = {RETRY_W{1'b0}};
`endif
      end else begin
         // Response window of an outstanding AT command; response beats timeout.
         if (cmd_out_q) begin
            rsp_timer_d = sat_inc(rsp_timer_q);
            if (at_rsp_rcvd) begin
               at_cmd_done_d = 1'b1;
               cmd_out_d     = 1'b0;
`ifdef SB_SCHED_RETRY_EN
               retry_cnt_d   = {RETRY_W{1'b0}};
`endif
            end else if (rsp_timer_q == TMO_LAST) begin
`ifdef SB_SCHED_RETRY_EN
               if (retry_cnt_q < RETRY_W'(MAX_RETRY)) begin
                  // Re-queue the command through normal arbitration.
                  retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                  cmd_out_d   = 1'b0;
                  pend_cmd_d  = 1'b1;
               end else begin
                  at_timeout_d = 1'b1;
                  cmd_out_d    = 1'b0;
                  retry_cnt_d  = {RETRY_W{1'b0}};
               end
`else
               at_timeout_d = 1'b1;
               cmd_out_d    = 1'b0;
`endif
            end else begin
               cmd_out_d = 1'b1;
            end
         end else begin
            rsp_timer_d = rsp_timer_q;
         end

         case (state_q)
            IDLE: begin
               if (arb_sel != SEL_NONE) begin
                  trans_sel_d = arb_sel;
                  cur_sel_d   = arb_sel;
                  timer_d     = CNT_ZERO;
                  if (arb_gnt[GNT_LT])  pend_lt_d  = 1'b0; else pend_lt_d  = pend_lt_q;
                  if (arb_gnt[GNT_RSP]) pend_rsp_d = 1'b0; else pend_rsp_d = pend_rsp_q;
                  if (arb_gnt[GNT_CMD]) pend_cmd_d = 1'b0; else pend_cmd_d = pend_cmd_d;
               end else begin
                  trans_sel_d = SEL_NONE;
               end
            end
            WAIT_SENT: begin
               timer_d = sat_inc(timer_q);
               if (trans_sent) begin
                  case (cur_sel_q)
                     SEL_LT:     lt_done_d     = 1'b1;
                     SEL_AT_RSP: at_rsp_done_d = 1'b1;
                     SEL_AT_CMD: begin
                        cmd_out_d   = 1'b1;
                        rsp_timer_d = CNT_ZERO;
                     end
                     default:    lt_done_d     = 1'b0;
                  endcase
                  cur_sel_d = SEL_NONE;
               end else if (timer_q == GUARD_LAST) begin
                  // Generator hang: flag it and abandon the transaction.
                  gen_err_d = 1'b1;
                  cur_sel_d = SEL_NONE;
               end else begin
                  cur_sel_d = cur_sel_q;
               end
            end
            default: cur_sel_d = cur_sel_q;
         endcase

         // A new request wins over a same-cycle clear.
         if (lt_req)     pend_lt_d  = 1'b1; else pend_lt_d  = pend_lt_d;
         if (at_rsp_req) pend_rsp_d = 1'b1; else pend_rsp_d = pend_rsp_d;
         if (at_cmd_req) pend_cmd_d = 1'b1; else pend_cmd_d = pend_cmd_d;
      end
   end

   assign trans_sel   = trans_sel_q;
   assign lt_done     = lt_done_q;
   assign at_cmd_done = at_cmd_done_q;
   assign at_rsp_done = at_rsp_done_q;
   assign at_timeout  = at_timeout_q;
   assign gen_err     = gen_err_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_sb_trans_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sb_trans_scheduler
// Scoreboard bench: expected trans_sel codes are queued when requests are
// driven and popped by a monitor whenever the scheduler issues a transaction.
// -----------------------------------------------------------------------------
module tb_sb_trans_scheduler;
   import sb_sched_pkg::*;

   logic       sb_clk;
   logic       rst;
   logic       lt_req, at_cmd_req, at_rsp_req, at_rsp_rcvd, trans_sent, disconnected_s;
   logic [2:0] trans_sel;
   logic       lt_done, at_cmd_done, at_rsp_done, at_timeout, gen_err, busy;

   int n_cmp = 0;
   int n_err = 0;
   int issue_cnt = 0;
   int lt_done_cnt = 0;
   int rsp_done_cnt = 0;
   int cmd_done_cnt = 0;
   int tmo_cnt = 0;
   logic [2:0] exp_q[$];

`ifdef SB_SCHED_RETRY_EN
   localparam int CMD_ISSUES = 3;
`else
   localparam int CMD_ISSUES = 1;
`endif

   sb_trans_scheduler dut (
      .sb_clk         (sb_clk),
      .rst            (rst),
      .lt_req         (lt_req),
      .at_cmd_req     (at_cmd_req),
      .at_rsp_req     (at_rsp_req),
      .at_rsp_rcvd    (at_rsp_rcvd),
      .trans_sent     (trans_sent),
      .disconnected_s (disconnected_s),
      .trans_sel      (trans_sel),
      .lt_done        (lt_done),
      .at_cmd_done    (at_cmd_done),
      .at_rsp_done    (at_rsp_done),
      .at_timeout     (at_timeout),
      .gen_err        (gen_err),
      .busy           (busy)
   );

   initial sb_clk = 1'b0;
   always #5 sb_clk = ~sb_clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor and pulse counters, sampled on the falling edge.
   always @(negedge sb_clk) begin
      if (trans_sel != SEL_NONE) begin
         issue_cnt++;
         if (exp_q.size() == 0) check_val("sel_unexpected", int'(trans_sel), int'(SEL_NONE));
         else check_val("sel_order", int'(trans_sel), int'(exp_q.pop_front()));
      end
      if (lt_done)     lt_done_cnt++;
      if (at_rsp_done) rsp_done_cnt++;
      if (at_cmd_done) cmd_done_cnt++;
      if (at_timeout)  tmo_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge sb_clk);
      #1;
   endtask

   task automatic pulse_sent();
      trans_sent = 1'b1;
      tick(1);
      trans_sent = 1'b0;
   endtask

   task automatic wait_issue(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         if (trans_sel != SEL_NONE) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   initial begin
      bit ok;
      bit got;
      int since;
      int sent_local;
      int snap;

      rst = 1'b0; disconnected_s = 1'b1;
      lt_req = 1'b0; at_cmd_req = 1'b0; at_rsp_req = 1'b0;
      at_rsp_rcvd = 1'b0; trans_sent = 1'b0;
      tick(2);
      check_val("rst_trans_sel", int'(trans_sel), 0);
      check_val("rst_busy", int'(busy), 0);
      check_val("rst_gen_err", int'(gen_err), 0);

      // Released while disconnected: stays in DISC.
      rst = 1'b1;
      tick(2);
      check_val("disc_busy", int'(busy), 1);
      disconnected_s = 1'b0;
      tick(1);
      check_val("idle_busy", int'(busy), 0);

      // Three simultaneous requests: LT, then AT rsp, then AT cmd.
      exp_q.push_back(SEL_LT); exp_q.push_back(SEL_AT_RSP); exp_q.push_back(SEL_AT_CMD);
      lt_req = 1'b1; at_rsp_req = 1'b1; at_cmd_req = 1'b1;
      tick(1);
      lt_req = 1'b0; at_rsp_req = 1'b0; at_cmd_req = 1'b0;
      check_val("lat_early", int'(trans_sel), 0);
      tick(1);
      check_val("lat_issue", int'(trans_sel), int'(SEL_LT));
      for (int k = 0; k < 3; k++) begin
         wait_issue(5, ok);
         check_val("prio_issue_seen", int'(ok), 1);
         tick(4);
         check_val("prio_one_at_a_time", issue_cnt, k + 1);
         pulse_sent();
      end
      tick(2);
      check_val("prio_lt_done", lt_done_cnt, 1);
      check_val("prio_rsp_done", rsp_done_cnt, 1);
      at_rsp_rcvd = 1'b1;
      tick(1);
      check_val("prio_cmd_done", int'(at_cmd_done), 1);
      at_rsp_rcvd = 1'b0;

      // AT command answered inside the response window.
      exp_q.push_back(SEL_AT_CMD);
      at_cmd_req = 1'b1; tick(1); at_cmd_req = 1'b0;
      wait_issue(5, ok);
      check_val("win_issue_seen", int'(ok), 1);
      tick(80);
      pulse_sent();
      tick(500);
      check_val("win_no_done_yet", cmd_done_cnt, 1);
      at_rsp_rcvd = 1'b1;
      tick(1);
      check_val("win_cmd_done", int'(at_cmd_done), 1);
      at_rsp_rcvd = 1'b0;
      tick(2);
      check_val("win_done_cnt", cmd_done_cnt, 2);
      check_val("win_no_timeout", tmo_cnt, 0);

      // AT command never answered.
      for (int k = 0; k < CMD_ISSUES; k++) exp_q.push_back(SEL_AT_CMD);
      at_cmd_req = 1'b1; tick(1); at_cmd_req = 1'b0;
      wait_issue(5, ok);
      check_val("tmo_issue_seen", int'(ok), 1);
      tick(2);
      pulse_sent();
      sent_local = 1; since = 0; got = 1'b0;
      for (int c = 0; c < 5000 && !got; c++) begin
         tick(1);
         since++;
         if (at_timeout) begin
            got = 1'b1;
         end else if (trans_sel != SEL_NONE) begin
            tick(2);
            pulse_sent();
            sent_local++;
            since = 0;
         end
      end
      check_val("tmo_seen", int'(got), 1);
      check_val("tmo_window", int'(since >= 999 && since <= 1001), 1);
      check_val("tmo_issues", sent_local, CMD_ISSUES);
      tick(2);
      check_val("tmo_cnt", tmo_cnt, 1);
      check_val("tmo_no_cmd_done", cmd_done_cnt, 2);

      // Generator hang: no trans_sent after issue.
      exp_q.push_back(SEL_LT);
      lt_req = 1'b1; tick(1); lt_req = 1'b0;
      wait_issue(5, ok);
      check_val("hang_issue_seen", int'(ok), 1);
      since = 0; got = 1'b0;
      for (int c = 0; c < 400 && !got; c++) begin
         tick(1);
         since++;
         if (gen_err) got = 1'b1;
      end
      check_val("hang_gen_err", int'(got), 1);
      check_val("hang_window", int'(since >= 254 && since <= 256), 1);
      check_val("hang_idle", int'(busy), 0);
      check_val("hang_no_lt_done", lt_done_cnt, 1);
      exp_q.push_back(SEL_LT);
      lt_req = 1'b1; tick(1); lt_req = 1'b0;
      wait_issue(5, ok);
      check_val("hang_next_issue", int'(ok), 1);
      tick(2);
      pulse_sent();
      tick(1);
      check_val("hang_next_done", lt_done_cnt, 2);
      check_val("hang_err_sticky", int'(gen_err), 1);

      // Disconnect during WAIT_SENT with a command pending.
      exp_q.push_back(SEL_AT_RSP);
      at_rsp_req = 1'b1; tick(1); at_rsp_req = 1'b0;
      wait_issue(5, ok);
      check_val("disc_issue_seen", int'(ok), 1);
      at_cmd_req = 1'b1; tick(1); at_cmd_req = 1'b0;
      tick(2);
      disconnected_s = 1'b1;
      tick(1);
      check_val("disc_gen_err_clr", int'(gen_err), 0);
      check_val("disc_busy_hi", int'(busy), 1);
      tick(3);
      pulse_sent();
      disconnected_s = 1'b0;
      snap = issue_cnt;
      tick(20);
      check_val("disc_no_reissue", issue_cnt, snap);
      check_val("disc_no_rsp_done", rsp_done_cnt, 1);
      check_val("disc_back_idle", int'(busy), 0);
      check_val("sb_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sb_trans_scheduler.md
Name: sb_trans_scheduler

Overview:
Arbitrates and sequences sideband (SB) transaction requests into the SB transaction generator FSM. Three requesters share one generator: LT (LSE/CLSE lane transaction), AT response (read response) and AT command (read command). The block latches requests, issues a one-cycle trans_sel code, then waits for trans_sent. For AT commands it supervises the response window. It sits between the control unit and the transaction generator, in the sb_clk domain.

Parameters:
RSP_TIMEOUT, 1000, sb_clk cycles allowed between AT command trans_sent and at_rsp_rcvd.
SENT_GUARD, 255, max sb_clk cycles from trans_sel issue to trans_sent before a generator-hang error.
MAX_RETRY, 2, AT command re-issues after response timeout (only with the optional feature).
CNT_W, 10, width of the shared timer; must satisfy 2^CNT_W > max(RSP_TIMEOUT, SENT_GUARD).

Ports:
sb_clk  in  1  SB clock
rst  in  1  reset; asynchronous, active-low
lt_req  in  1  pulse: request LT transaction
at_cmd_req  in  1  pulse: request AT read command
at_rsp_req  in  1  pulse: request AT read response
at_rsp_rcvd  in  1  pulse: AT response received from the far end (receive path)
trans_sent  in  1  generator done pulse
disconnected_s  in  1  generator is in the disconnected state
trans_sel  out  3  to generator: 0 none, 2 AT cmd, 3 AT rsp, 4 LT; one-cycle pulse
lt_done  out  1  pulse: LT transaction sent
at_cmd_done  out  1  pulse: AT command answered
at_rsp_done  out  1  pulse: AT response sent
at_timeout  out  1  pulse: AT command gave up
gen_err  out  1  sticky: SENT_GUARD expired; cleared by reset or disconnect
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state DISC, pend_lt/pend_cmd/pend_rsp = 0, timer = 0, every output 0. All outputs are registered.
- Pending flags: set by the matching req pulse in any state except DISC. Cleared when that request is issued. A req pulse arriving in the same cycle as the clear sets the flag again (set wins).
- DISC: all pending flags and the timer are cleared, and req pulses are ignored. Go to IDLE when disconnected_s = 0.
- IDLE:
  - Fixed priority: LT > AT rsp > AT cmd.
  - If any flag is pending, drive trans_sel with the winner's code for exactly 1 cycle, clear that flag, load timer = 0, go to WAIT_SENT.
  - While a command is outstanding (cmd_out = 1), AT cmd is not eligible; LT and AT rsp are still served.
- WAIT_SENT:
  - Timer increments each cycle.
  - On trans_sent:
    - LT: pulse lt_done.
    - AT rsp: pulse at_rsp_done.
    - AT cmd: set cmd_out = 1 and load rsp_timer = 0.
    - Then return to IDLE.
  - If timer reaches SENT_GUARD: set gen_err, drop the transaction, go to IDLE.
- Response window: rsp_timer is a separate CNT_W counter that runs while cmd_out = 1, in any non-DISC state.
  - at_rsp_rcvd while cmd_out = 1: pulse at_cmd_done, clear cmd_out.
  - at_rsp_rcvd while cmd_out = 0: ignored.
  - rsp_timer reaching RSP_TIMEOUT: timeout handling (see Optional Feature).
  - at_rsp_rcvd and timeout in the same cycle: the response wins.
- disconnected_s = 1 in any state: next state is DISC. Any in-flight transaction is dropped without a done pulse, and cmd_out and gen_err are cleared.
- Latency: a req pulse in IDLE with nothing else pending gives trans_sel on the 2nd sb_clk edge after the request.
- trans_sent outside WAIT_SENT is ignored.
- Counters saturate; they never wrap.

Optional Feature:
SB_SCHED_RETRY_EN
- Defined: on response timeout with retry_cnt < MAX_RETRY, increment retry_cnt, clear cmd_out and set pend_cmd, so the command is re-issued through normal arbitration. When retry_cnt = MAX_RETRY, pulse at_timeout and clear cmd_out. retry_cnt resets to 0 on at_cmd_done, at_timeout or DISC.
- Undefined: a response timeout immediately pulses at_timeout and clears cmd_out. There is no retry_cnt register.

Decomposition:
- Package sb_sched_pkg holds:
  - the state enum: DISC, IDLE, WAIT_SENT;
  - the trans_sel code constants: SEL_NONE=0, SEL_AT_CMD=2, SEL_AT_RSP=3, SEL_LT=4. The generator uses the same codes.
- One natural sub-module: sb_sched_arb, a combinational fixed-priority picker over {pend_lt, pend_rsp, pend_cmd & ~cmd_out} returning the code and a one-hot grant.

Test Plan:
- Reset with disconnected_s = 1, then release -> stays in DISC, busy = 1. Drop disconnected_s -> IDLE after 1 cycle, busy = 0.
- lt_req, at_rsp_req and at_cmd_req pulsed in the same cycle -> trans_sel sequence 4, 3, 2. Each is issued only after the previous trans_sent; lt_done and at_rsp_done pulse once each.
- AT cmd issued, trans_sent at cycle +80, at_rsp_rcvd 500 cycles later -> at_cmd_done pulse, no at_timeout.
- AT cmd, no response:
  - Retry build (MAX_RETRY = 2): trans_sel = 2 issued three times total, then at_timeout.
  - Non-retry build: at_timeout after 1000 cycles, single issue.
- No trans_sent after issue -> gen_err = 1 at 255 cycles, state IDLE. Next lt_req is still served.
- disconnected_s = 1 during WAIT_SENT with pend_cmd set -> DISC, pending flags cleared, no done pulses, gen_err = 0.
